// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_pkg
// Description : Shared widths, lane defaults and FSM states for the SIMD feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_pkg;

    localparam int unsigned SIMD_LANES_DEF     = 4;
    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned WEIGHT_WIDTH_DEF   = 8;
    localparam int unsigned ACC_WIDTH_DEF      = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    // Activation lanes are fixed-width on the accelerator side
    localparam int unsigned ACT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } feeder_state_e;

    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : simd_lane_packer
// Description : Lane registers, write index and lane mask for one SIMD vector.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_lane_packer
    import simd_pkg::*;
#(
    parameter int unsigned SIMD_LANES   = SIMD_LANES_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           wr_en_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [WEIGHT_WIDTH-1:0]        wr_weight_i,
    output logic [SIMD_LANES*DATA_WIDTH-1:0]   vec_data_o,
    output logic [SIMD_LANES*WEIGHT_WIDTH-1:0] vec_weight_o,
    output logic [SIMD_LANES-1:0]          mask_o,
    output logic                           last_lane_o
);

    localparam int unsigned IDX_W = idx_width(SIMD_LANES);

    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [SIMD_LANES*DATA_WIDTH-1:0]   data_q, data_d;
    logic [SIMD_LANES*WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic [SIMD_LANES-1:0]              mask_q, mask_d;

    // Clear has priority: the top never writes and clears in the same cycle
    always_comb begin
        idx_d    = idx_q;
        data_d   = data_q;
        weight_d = weight_q;
        mask_d   = mask_q;
        if (clear_i) begin
            idx_d    = '0;
            data_d   = '0;
            weight_d = '0;
            mask_d   = '0;
        end else if (wr_en_i) begin
            for (int l = 0; l < int'(SIMD_LANES); l++) begin
                if (idx_q == IDX_W'(l)) begin
                    data_d[l*DATA_WIDTH +: DATA_WIDTH]       = wr_data_i;
                    weight_d[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wr_weight_i;
                    mask_d[l]                                = 1'b1;
                end
            end
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            data_q   <= '0;
            weight_q <= '0;
            mask_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            data_q   <= data_d;
            weight_q <= weight_d;
            mask_q   <= mask_d;
        end
    end

    assign vec_data_o   = data_q;
    assign vec_weight_o = weight_q;
    assign mask_o       = mask_q;
    assign last_lane_o  = (idx_q == IDX_W'(SIMD_LANES - 1));

endmodule
`default_nettype wire

// File: rtl/simd_vector_feeder.sv
`default_nettype none
// ============================================================================
// Module      : simd_vector_feeder
// Description : Packs element pairs into a SIMD vector, issues it to the
//               accelerator and returns the captured results to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_vector_feeder
    import simd_pkg::*;
#(
    parameter int unsigned SIMD_LANES     = SIMD_LANES_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned WEIGHT_WIDTH   = WEIGHT_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic [WEIGHT_WIDTH-1:0]              in_weight,
    input  logic                                 in_last,
    output logic                                 acc_enable,
    output logic                                 acc_simd_start,
    output logic                                 acc_data_valid,
    output logic [SIMD_LANES*DATA_WIDTH-1:0]     acc_vec_data,
    output logic [SIMD_LANES*WEIGHT_WIDTH-1:0]   acc_vec_weight,
    input  logic                                 acc_result_valid,
    input  logic [SIMD_LANES*ACC_WIDTH-1:0]      acc_vec_mac,
    input  logic [SIMD_LANES*ACT_WIDTH-1:0]      acc_vec_act,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SIMD_LANES*ACC_WIDTH-1:0]      out_mac,
    output logic [SIMD_LANES*ACT_WIDTH-1:0]      out_act,
    output logic [SIMD_LANES-1:0]                out_lane_mask,
    output logic                                 timeout_err,
    output logic                                 idle
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    feeder_state_e                   state_q;
    logic [CNT_W-1:0]                tmo_cnt_q;
    logic [SIMD_LANES*ACC_WIDTH-1:0] out_mac_q;
    logic [SIMD_LANES*ACT_WIDTH-1:0] out_act_q;
    logic                            timeout_err_q;

    logic                            accept;
    logic                            wait_expired;
    logic                            pack_clear;
    logic                            last_lane;
    logic [SIMD_LANES-1:0]           lane_mask;

    assign accept       = in_valid & in_ready;
    assign wait_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // A result arriving on the expiry cycle wins over the timeout
    assign pack_clear   = ((state_q == ST_WAIT) & ~acc_result_valid & wait_expired)
                        | ((state_q == ST_DRAIN) & out_ready);

    simd_lane_packer #(
        .SIMD_LANES   (SIMD_LANES),
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pack_clear),
        .wr_en_i      (accept),
        .wr_data_i    (in_data),
        .wr_weight_i  (in_weight),
        .vec_data_o   (acc_vec_data),
        .vec_weight_o (acc_vec_weight),
        .mask_o       (lane_mask),
        .last_lane_o  (last_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            tmo_cnt_q     <= '0;
            out_mac_q     <= '0;
            out_act_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (accept && (last_lane || in_last)) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (acc_result_valid) begin
                        out_mac_q <= acc_vec_mac;
                        out_act_q <= acc_vec_act;
                        state_q   <= ST_DRAIN;
                    end else if (wait_expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_FILL;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    // in_ready is held low while reset is asserted so every output reads 0
    assign in_ready       = (state_q == ST_FILL) & ~rst;
    assign idle           = in_ready & ~(|lane_mask);
    assign acc_enable     = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
    assign acc_simd_start = (state_q == ST_ISSUE);
    assign acc_data_valid = (state_q == ST_ISSUE);
    assign out_valid      = (state_q == ST_DRAIN);
    assign out_mac        = out_mac_q;
    assign out_act        = out_act_q;
    assign out_lane_mask  = lane_mask;
    assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_simd_vector_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_vector_feeder
// Description : Self-checking bench with an accelerator model and a per-vector
//               reference built from element lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_vector_feeder;

    localparam int L   = 4;
    localparam int DW  = 8;
    localparam int WW  = 8;
    localparam int AW  = 16;
    localparam int TMO = 64;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_TMO    = 1;
    localparam int MODE_RST    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_last;
    logic [DW-1:0]   in_data;
    logic [WW-1:0]   in_weight;
    logic            acc_enable, acc_simd_start, acc_data_valid;
    logic [L*DW-1:0] acc_vec_data;
    logic [L*WW-1:0] acc_vec_weight;
    logic            acc_result_valid;
    logic [L*AW-1:0] acc_vec_mac;
    logic [L*8-1:0]  acc_vec_act;
    logic            out_valid, out_ready;
    logic [L*AW-1:0] out_mac;
    logic [L*8-1:0]  out_act;
    logic [L-1:0]    out_lane_mask;
    logic            timeout_err, idle;

    int n_checks = 0;
    int n_errors = 0;

    simd_vector_feeder #(
        .SIMD_LANES(L), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_weight(in_weight), .in_last(in_last),
        .acc_enable(acc_enable), .acc_simd_start(acc_simd_start),
        .acc_data_valid(acc_data_valid), .acc_vec_data(acc_vec_data),
        .acc_vec_weight(acc_vec_weight), .acc_result_valid(acc_result_valid),
        .acc_vec_mac(acc_vec_mac), .acc_vec_act(acc_vec_act),
        .out_valid(out_valid), .out_ready(out_ready), .out_mac(out_mac),
        .out_act(out_act), .out_lane_mask(out_lane_mask),
        .timeout_err(timeout_err), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Accelerator behaviour: per-lane product, activation clamps to 8 bits
    function automatic logic [L*AW-1:0] mac_of(input logic [L*DW-1:0] d, input logic [L*WW-1:0] w);
        logic [L*AW-1:0] r;
        int p;
        r = '0;
        for (int l = 0; l < L; l++) begin
            p = int'(d[l*DW +: DW]) * int'(w[l*WW +: WW]);
            r[l*AW +: AW] = AW'(p);
        end
        return r;
    endfunction

    function automatic logic [L*8-1:0] act_of(input logic [L*AW-1:0] m);
        logic [L*8-1:0] r;
        int v;
        r = '0;
        for (int l = 0; l < L; l++) begin
            v = int'(m[l*AW +: AW]);
            r[l*8 +: 8] = (v > 255) ? 8'hFF : 8'(v);
        end
        return r;
    endfunction

    task automatic run_vec(input int n, input logic [L*DW-1:0] dv, input logic [L*WW-1:0] wv,
                           input int delay, input int stall, input int mode);
        logic [L*DW-1:0] exp_data;
        logic [L*WW-1:0] exp_wt;
        logic [L*AW-1:0] exp_mac;
        logic [L*8-1:0]  exp_act;
        logic [L-1:0]    exp_mask;
        int              pulses;

        exp_data = '0; exp_wt = '0; exp_mask = '0;
        for (int i = 0; i < n; i++) begin
            exp_data[i*DW +: DW] = dv[i*DW +: DW];
            exp_wt[i*WW +: WW]   = wv[i*WW +: WW];
            exp_mask[i]          = 1'b1;
        end
        exp_mac = mac_of(exp_data, exp_wt);
        exp_act = act_of(exp_mac);

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("in_ready_fill", in_ready, 1);
            if (i == 0) check_eq("idle_empty", idle, 1);
            check_eq("start_low_fill", acc_simd_start, 0);
            check_eq("enable_low_fill", acc_enable, 0);
            in_valid  = 1'b1;
            in_data   = dv[i*DW +: DW];
            in_weight = wv[i*WW +: WW];
            in_last   = (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = DW'($urandom);
        check_eq("issue_start", acc_simd_start, 1);
        check_eq("issue_valid", acc_data_valid, 1);
        check_eq("issue_enable", acc_enable, 1);
        check_eq("issue_in_ready", in_ready, 0);
        check_eq("issue_vec_data", acc_vec_data, exp_data);
        check_eq("issue_vec_weight", acc_vec_weight, exp_wt);

        @(negedge clk);
        check_eq("wait_start_low", acc_simd_start, 0);
        check_eq("wait_valid_low", acc_data_valid, 0);
        check_eq("wait_enable", acc_enable, 1);

        if (mode == MODE_TMO) begin
            pulses = int'(timeout_err);
            for (int c = 1; c < TMO; c++) begin
                @(negedge clk);
                pulses += int'(timeout_err);
            end
            check_eq("timeout_not_early", pulses, 0);
            @(negedge clk);
            check_eq("timeout_pulse", timeout_err, 1);
            check_eq("timeout_no_out_valid", out_valid, 0);
            check_eq("timeout_in_ready", in_ready, 1);
            check_eq("timeout_idle", idle, 1);
            check_eq("timeout_enable_low", acc_enable, 0);
            @(negedge clk);
            check_eq("timeout_one_cycle", timeout_err, 0);
        end else if (mode == MODE_RST) begin
            @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check_eq("rst_enable", acc_enable, 0);
            check_eq("rst_start", acc_simd_start, 0);
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_idle", idle, 0);
            check_eq("rst_vec_data", acc_vec_data, 0);
            check_eq("rst_mask", out_lane_mask, 0);
            check_eq("rst_out_valid", out_valid, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check_eq("post_rst_in_ready", in_ready, 1);
            check_eq("post_rst_idle", idle, 1);
        end else begin
            for (int c = 0; c < delay; c++) @(negedge clk);
            check_eq("wait_vec_stable", acc_vec_data, exp_data);
            check_eq("wait_weight_stable", acc_vec_weight, exp_wt);
            acc_result_valid = 1'b1;
            acc_vec_mac      = mac_of(acc_vec_data, acc_vec_weight);
            acc_vec_act      = act_of(acc_vec_mac);
            @(negedge clk);
            acc_result_valid = 1'b0;
            acc_vec_mac      = {$urandom, $urandom};
            acc_vec_act      = $urandom;
            check_eq("drain_valid", out_valid, 1);
            check_eq("drain_mac", out_mac, exp_mac);
            check_eq("drain_act", out_act, exp_act);
            check_eq("drain_mask", out_lane_mask, exp_mask);
            check_eq("drain_in_ready", in_ready, 0);
            check_eq("drain_enable", acc_enable, 0);
            check_eq("drain_no_timeout", timeout_err, 0);
            for (int s = 0; s < stall; s++) begin
                acc_result_valid = 1'b1;
                @(negedge clk);
                acc_result_valid = 1'b0;
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_mac", out_mac, exp_mac);
                check_eq("stall_act", out_act, exp_act);
                check_eq("stall_mask", out_lane_mask, exp_mask);
                check_eq("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("post_drain_valid", out_valid, 0);
            check_eq("post_drain_in_ready", in_ready, 1);
            check_eq("post_drain_idle", idle, 1);
            check_eq("post_drain_mask", out_lane_mask, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_weight = '0;
        acc_result_valid = 1'b0; acc_vec_mac = '0; acc_vec_act = '0;
        out_ready = 1'b0;
        #1;
        check_eq("reset_enable", acc_enable, 0);
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_mac", out_mac, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_release_in_ready", in_ready, 1);
        check_eq("reset_release_idle", idle, 1);

        run_vec(4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 3, 0, MODE_NORMAL);
        run_vec(2, {8'd0, 8'd0, 8'd20, 8'd10}, {8'd0, 8'd0, 8'd4, 8'd3}, 2, 0, MODE_NORMAL);
        run_vec(4, {8'd9, 8'd8, 8'd7, 8'd6}, {8'd1, 8'd2, 8'd3, 8'd4}, 1, 5, MODE_NORMAL);
        run_vec(3, {8'd0, 8'd5, 8'd6, 8'd7}, {8'd0, 8'd9, 8'd9, 8'd9}, 0, 0, MODE_TMO);
        run_vec(4, {8'd11, 8'd12, 8'd13, 8'd14}, {8'd2, 8'd2, 8'd2, 8'd2}, 0, 1, MODE_NORMAL);
        run_vec(4, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 0, MODE_RST);
        run_vec(4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 4, 0, MODE_NORMAL);
        run_vec(4, {8'd255, 8'd16, 8'd1, 8'd200}, {8'd255, 8'd16, 8'd0, 8'd2}, 2, 1, MODE_NORMAL);
        run_vec(1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd6}, TMO - 1, 0, MODE_NORMAL);

        for (int t = 0; t < 40; t++) begin
            run_vec(int'($urandom_range(1, L)), $urandom, $urandom,
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0) ? MODE_TMO : MODE_NORMAL);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
